// File: rtl/backtracker.sv
// Conflict backtracker: unwinds the trace to the newest decision,
// then re-pushes it as a forced, flipped assignment.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module backtracker #(
  parameter int VAR_BITS = `MAX_VARS_BITS,
  parameter int CNT_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                trace_empty,
  input  logic                trace_type,
  input  logic                trace_val,
  input  logic [VAR_BITS-1:0] trace_var,
  output logic                trace_pop,
  output logic                trace_push,
  output logic                trace_type_in,
  output logic                trace_val_in,
  output logic [VAR_BITS-1:0] trace_var_in,
  input  logic                ds_empty,
  input  logic [VAR_BITS-1:0] ds_idx,
  output logic                ds_pop,
  output logic                dec_write,
  output logic [VAR_BITS-1:0] back_dec_idx,
  output logic                unassign_en,
  output logic [VAR_BITS-1:0] unassign_var,
  output logic                assign_en,
  output logic [VAR_BITS-1:0] assign_var,
  output logic                assign_val,
  output logic                busy,
  output logic                done,
  output logic                unsat,
  output logic [CNT_BITS-1:0] pop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_FLIP,
    S_DONE,
    S_UNSAT
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [VAR_BITS-1:0] lat_var;
  logic                lat_val;
  logic                latch;
  logic                cnt_clr;
  logic                cnt_inc;

  // State, latched decision and saturating pop counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      lat_var   <= '0;
      lat_val   <= 1'b0;
      pop_count <= '0;
    end else begin
      state <= state_n;
      if (latch) begin
        lat_var <= trace_var;
        lat_val <= trace_val;
      end
      if (cnt_clr) begin
        pop_count <= '0;
      end else if (cnt_inc && (pop_count != {CNT_BITS{1'b1}})) begin
        pop_count <= pop_count + 1'b1;
      end
    end
  end

  // Next state and request outputs from state and stack heads.
  always_comb begin
    state_n       = state;
    latch         = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    trace_pop     = 1'b0;
    trace_push    = 1'b0;
    trace_type_in = 1'b0;
    trace_val_in  = 1'b0;
    trace_var_in  = '0;
    ds_pop        = 1'b0;
    dec_write     = 1'b0;
    back_dec_idx  = '0;
    unassign_en   = 1'b0;
    unassign_var  = '0;
    assign_en     = 1'b0;
    assign_var    = '0;
    assign_val    = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unsat         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SCAN;
          cnt_clr = 1'b1;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if (trace_empty) begin
          state_n = S_UNSAT;
        end else begin
          trace_pop    = 1'b1;
          unassign_en  = 1'b1;
          unassign_var = trace_var;
          cnt_inc      = 1'b1;
          if (!trace_type) begin
            latch   = 1'b1;
            state_n = S_FLIP;
          end
        end
      end
      S_FLIP: begin
        busy          = 1'b1;
        trace_push    = 1'b1;
        trace_type_in = 1'b1;
        trace_val_in  = ~lat_val;
        trace_var_in  = lat_var;
        assign_en     = 1'b1;
        assign_var    = lat_var;
        assign_val    = ~lat_val;
        dec_write     = 1'b1;
        if (!ds_empty) begin
          ds_pop       = 1'b1;
          back_dec_idx = ds_idx;
        end
        state_n = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = S_IDLE;
      end
      S_UNSAT: begin
        unsat = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_backtracker.sv
// Bench for backtracker: stack environment, reference walk of
// the trace, and an event scoreboard checked by a monitor.
module tb_backtracker;

  localparam int VB = 6;
  localparam int CB = 8;

  localparam int K_UN   = 0;
  localparam int K_FLIP = 1;
  localparam int K_DONE = 2;
  localparam int K_UNS  = 3;

  logic          clock;
  logic          reset;
  logic          start;
  logic          trace_empty;
  logic          trace_type;
  logic          trace_val;
  logic [VB-1:0] trace_var;
  logic          trace_pop;
  logic          trace_push;
  logic          trace_type_in;
  logic          trace_val_in;
  logic [VB-1:0] trace_var_in;
  logic          ds_empty;
  logic [VB-1:0] ds_idx;
  logic          ds_pop;
  logic          dec_write;
  logic [VB-1:0] back_dec_idx;
  logic          unassign_en;
  logic [VB-1:0] unassign_var;
  logic          assign_en;
  logic [VB-1:0] assign_var;
  logic          assign_val;
  logic          busy;
  logic          done;
  logic          unsat;
  logic [CB-1:0] pop_count;

  backtracker #(.VAR_BITS(VB), .CNT_BITS(CB)) dut (
    .clock(clock), .reset(reset), .start(start),
    .trace_empty(trace_empty), .trace_type(trace_type),
    .trace_val(trace_val), .trace_var(trace_var),
    .trace_pop(trace_pop), .trace_push(trace_push),
    .trace_type_in(trace_type_in),
    .trace_val_in(trace_val_in),
    .trace_var_in(trace_var_in),
    .ds_empty(ds_empty), .ds_idx(ds_idx),
    .ds_pop(ds_pop), .dec_write(dec_write),
    .back_dec_idx(back_dec_idx),
    .unassign_en(unassign_en), .unassign_var(unassign_var),
    .assign_en(assign_en), .assign_var(assign_var),
    .assign_val(assign_val),
    .busy(busy), .done(done), .unsat(unsat),
    .pop_count(pop_count)
  );

  typedef struct packed {
    logic          t;
    logic          v;
    logic [VB-1:0] x;
  } ent_t;

  typedef struct {
    int kind;
    int v;
    int val;
    int idx;
    int dp;
    int cnt;
  } exp_t;

  ent_t          trace_q[$];
  logic [VB-1:0] ds_q[$];
  exp_t          exp_q[$];

  int   total = 0;
  int   bad = 0;
  bit   pend_pop, pend_push, pend_dspop;
  ent_t pend_ent;
  bit   prev_unsat;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input int act,
                     input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic drive_heads();
    trace_empty = (trace_q.size() == 0);
    if (trace_q.size() != 0) begin
      trace_type = trace_q[$].t;
      trace_val  = trace_q[$].v;
      trace_var  = trace_q[$].x;
    end else begin
      trace_type = 1'b0;
      trace_val  = 1'b1;
      trace_var  = VB'(9);
    end
    ds_empty = (ds_q.size() == 0);
    ds_idx   = ds_empty ? VB'(5) : ds_q[$];
  endtask

  task automatic add(input bit t, input bit v, input int x);
    ent_t e;
    e = {t, v, VB'(x)};
    trace_q.push_back(e);
  endtask

  task automatic clear_env();
    trace_q.delete();
    ds_q.delete();
    drive_heads();
  endtask

  task automatic push_exp(input int k, input int v,
                          input int val, input int idx,
                          input int dp, input int cnt);
    exp_t e;
    e.kind = k; e.v = v; e.val = val;
    e.idx = idx; e.dp = dp; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Reference: walk from the top, unassign each entry, stop at
  // the first decision and flip it; no decision means unsat.
  task automatic model(output int pops, output bit flip);
    int idx;
    int dp;
    pops = 0;
    flip = 0;
    for (int i = trace_q.size() - 1; i >= 0; i--) begin
      push_exp(K_UN, int'(trace_q[i].x), 0, 0, 0, 0);
      pops++;
      if (trace_q[i].t == 1'b0) begin
        dp  = (ds_q.size() != 0) ? 1 : 0;
        idx = dp ? int'(ds_q[$]) : 0;
        push_exp(K_FLIP, int'(trace_q[i].x),
                 trace_q[i].v ? 0 : 1, idx, dp, 0);
        flip = 1;
        break;
      end
    end
    push_exp(flip ? K_DONE : K_UNS, 0, 0, 0, 0,
             (pops > 255) ? 255 : pops);
  endtask

  // Environment stacks: apply the requests seen before the edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (pend_pop && trace_q.size() != 0)
        void'(trace_q.pop_back());
      if (pend_push) trace_q.push_back(pend_ent);
      if (pend_dspop && ds_q.size() != 0)
        void'(ds_q.pop_back());
      drive_heads();
    end
  end

  task automatic take(input int kind, input string nm,
                      output exp_t e, output bit ok);
    total++;
    ok = 0;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got unexpected event required none",
               nm);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind) begin
      bad++;
      $display("FAIL %s: got kind %0d required %0d",
               nm, kind, e.kind);
    end else begin
      ok = 1;
    end
  endtask

  // Monitor: compare each presented event with the scoreboard.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clock);
      pend_pop   = trace_pop;
      pend_push  = trace_push;
      pend_dspop = ds_pop;
      pend_ent   = {trace_type_in, trace_val_in, trace_var_in};
      if (reset) begin
        prev_unsat = 0;
      end else begin
        chk("excl", int'((trace_pop && trace_push) ||
            (assign_en && unassign_en)), 0);
        if (unassign_en) begin
          take(K_UN, "unassign", e, ok);
          if (ok) begin
            chk("unassign_var", int'(unassign_var), e.v);
            chk("trace_pop", int'(trace_pop), 1);
          end
        end
        if (trace_push) begin
          take(K_FLIP, "flip", e, ok);
          if (ok) begin
            chk("push_var", int'(trace_var_in), e.v);
            chk("push_val", int'(trace_val_in), e.val);
            chk("push_type", int'(trace_type_in), 1);
            chk("assign_en", int'(assign_en), 1);
            chk("assign_var", int'(assign_var), e.v);
            chk("assign_val", int'(assign_val), e.val);
            chk("dec_write", int'(dec_write), 1);
            chk("back_dec_idx", int'(back_dec_idx), e.idx);
            chk("ds_pop", int'(ds_pop), e.dp);
          end
        end
        if (done) begin
          take(K_DONE, "done", e, ok);
          if (ok) chk("done_cnt", int'(pop_count), e.cnt);
        end
        if (unsat && !prev_unsat) begin
          take(K_UNS, "unsat", e, ok);
          if (ok) chk("unsat_cnt", int'(pop_count), e.cnt);
        end
        prev_unsat = unsat;
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk(nm, int'({trace_pop, trace_push, ds_pop, dec_write,
        assign_en, unassign_en, busy, done, unsat}), 0);
    chk({nm, "_cnt"}, int'(pop_count), 0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk_zero("reset_outs");
    exp_q.delete();
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    clear_env();
  endtask

  task automatic run_case(input string nm, input bit poke,
                          input int rst_at);
    int pops;
    bit flip;
    bit fin;
    int cyc;
    model(pops, flip);
    drive_heads();
    start = 1'b1;
    fin = 0;
    cyc = 0;
    for (int c = 1; c <= 64 && !fin; c++) begin
      @(posedge clock);
      #1;
      start = poke && (c == 1);
      if (rst_at == c) begin
        reset = 1'b1;
        #1;
        chk_zero("midscan_reset");
        exp_q.delete();
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clear_env();
        return;
      end
      @(negedge clock);
      if (done || unsat) begin
        fin = 1;
        cyc = c;
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got none required finish", nm);
      do_reset();
      return;
    end
    chk({nm, "_latency"}, cyc, pops + 2);
    if (flip) begin
      @(negedge clock);
      chk({nm, "_done_once"}, int'({busy, done, unsat}), 0);
      chk({nm, "_drain"}, exp_q.size(), 0);
    end else begin
      @(posedge clock);
      #1;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (2) @(negedge clock);
      chk({nm, "_sticky"}, int'({busy, unsat, done}), 2);
      chk({nm, "_keep_cnt"}, int'(pop_count), pops);
      chk({nm, "_drain"}, exp_q.size(), 0);
      do_reset();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_env();
    #1;
    chk_zero("reset_init");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk_zero("idle_after_reset");

    clear_env();
    ds_q.push_back(VB'(3));
    add(0, 1, 5);
    run_case("single", 0, 0);

    clear_env();
    ds_q.push_back(VB'(9));
    add(0, 0, 4); add(1, 0, 2); add(1, 1, 7);
    run_case("three", 0, 0);

    clear_env();
    add(1, 0, 6); add(1, 1, 1);
    run_case("forced_only", 0, 0);

    clear_env();
    run_case("empty", 0, 0);

    clear_env();
    ds_q.push_back(VB'(11));
    add(0, 0, 4); add(1, 0, 2); add(1, 1, 7);
    run_case("abort", 0, 2);
    ds_q.push_back(VB'(11));
    add(0, 0, 4); add(1, 0, 2); add(1, 1, 7);
    run_case("restart", 0, 0);

    clear_env();
    add(0, 1, 6); add(1, 1, 3);
    run_case("ds_empty", 1, 0);

    for (int n = 0; n < 40; n++) begin
      int d;
      int s;
      clear_env();
      d = $urandom_range(0, 5);
      for (int i = 0; i < d; i++)
        add($urandom_range(0, 2) != 0, $urandom_range(0, 1),
            $urandom_range(0, (1 << VB) - 1));
      s = $urandom_range(0, 2);
      for (int i = 0; i < s; i++)
        ds_q.push_back(VB'($urandom_range(0, (1 << VB) - 1)));
      run_case("rand", $urandom_range(0, 3) == 0, 0);
    end

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/backtracker.md
BACKTRACKER -- requirements
Module: backtracker

Interface
REQ-001 VAR_BITS, default `MAX_VARS_BITS, width of variable and decider indices.
REQ-002 CNT_BITS, default 8, width of the pop counter.
REQ-003 clock  in  1  system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces IDLE and clears all registers immediately.
REQ-005 start  in  1  conflict pulse from control; requests a backtrack.
REQ-006 trace_empty  in  1  trace stack empty.
REQ-007 trace_type  in  1  top entry type (0 decide, 1 forced).
REQ-008 trace_val  in  1  top entry value.
REQ-009 trace_var  in  VAR_BITS  top entry variable.
REQ-010 trace_pop  out  1  pop trace stack this cycle.
REQ-011 trace_push, trace_type_in, trace_val_in  out  1 each  push request with type and value of the flipped decision.
REQ-012 trace_var_in  out  VAR_BITS  variable of the flipped decision.
REQ-013 ds_empty  in  1  decider stack empty; ds_idx  in  VAR_BITS  decider stack top.
REQ-014 ds_pop  out  1  pop decider stack.
REQ-015 dec_write  out  1  load decider index; back_dec_idx  out  VAR_BITS  index to load.
REQ-016 unassign_en  out  1, unassign_var  out  VAR_BITS  clear an assignment.
REQ-017 assign_en  out  1, assign_var  out  VAR_BITS, assign_val  out  1  write an assignment.
REQ-018 busy, done, unsat  out  1 each  status; pop_count  out  CNT_BITS  entries popped by the last backtrack.

Function
REQ-019 FSM states IDLE, SCAN, FLIP, DONE, UNSAT; state and latched fields registered, all request outputs combinational from state and stack heads.
REQ-020 IDLE: start=1 -> SCAN next edge, pop_count cleared; start=0 -> stay.
REQ-021 SCAN, trace_empty=1: no pop -> UNSAT.
REQ-022 SCAN, trace_empty=0: trace_pop=1, unassign_en=1, unassign_var=trace_var, pop_count increments (saturates at all-ones).
REQ-023 SCAN, trace_type=1: stay in SCAN; next cycle sees the new top.
REQ-024 SCAN, trace_type=0: latch trace_var and trace_val -> FLIP.
REQ-025 FLIP, single cycle: trace_push=1, trace_type_in=1, trace_val_in=~latched val, trace_var_in=latched var; assign_en=1 with the same var/val.
REQ-026 FLIP: if ds_empty=0, ds_pop=1, dec_write=1, back_dec_idx=ds_idx; if ds_empty=1, dec_write=1, back_dec_idx=0, no pop.
REQ-027 FLIP always -> DONE; push never meets a full trace stack, since at least one entry was popped.
REQ-028 DONE: done=1 for exactly one cycle -> IDLE.
REQ-029 UNSAT: unsat=1 held until reset; start ignored.
REQ-030 busy=1 in SCAN, FLIP, DONE; 0 in IDLE and UNSAT.
REQ-031 start while busy=1 or in UNSAT is ignored; not queued.
REQ-032 Latency for N popped entries (last is a decision): start edge +1 SCAN entry, N SCAN cycles, 1 FLIP, done in the following cycle.
REQ-033 At most one of trace_pop or trace_push per cycle; assign_en and unassign_en never both high.

Reset
REQ-034 Reset asserted in any state, including mid-SCAN: state=IDLE, latched var/val=0, pop_count=0 immediately, without waiting for a clock edge.
REQ-035 Reset asserted: all outputs 0 (trace_pop, trace_push, ds_pop, dec_write, assign_en, unassign_en, busy, done, unsat).
REQ-036 Reset deasserted: first possible transition is IDLE->SCAN on a start seen at a rising edge.

Verification
REQ-037 Trace top=(decide,var 5,val 1), ds_idx=3; pulse start -> one pop, unassign 5; FLIP pushes (forced,5,0), assigns 5=0, dec_write with 3; done 3 cycles after start; pop_count=1.
REQ-038 Trace top-down (F,7,1),(F,2,0),(D,4,0) -> 3 consecutive pops unassigning 7,2,4; push (F,4,1); pop_count=3.
REQ-039 Trace holds only forced entries (F,1,1),(F,6,0) -> 2 pops, then trace_empty -> unsat=1 sticky; done never asserted; later start ignored.
REQ-040 Trace empty at start -> UNSAT after 1 SCAN cycle, pop_count=0.
REQ-041 Reset asserted in the second SCAN cycle of REQ-038 -> all outputs 0 immediately; start after reset release -> backtrack restarts cleanly.
REQ-042 Decision found with ds_empty=1 -> dec_write=1, back_dec_idx=0, ds_pop=0; start pulsed during SCAN has no effect.
